// File: rtl/nic_pwr_seq_ctrl.sv
// OCP NIC3 multi-rail power sequencer: ordered rail enable with per-step PG
// gating and delays, reverse-order power-down, PERST_N release and fault latch.
module nic_pwr_seq_ctrl #(
    parameter int NUM_RAILS  = 4,
    parameter int DLY_W      = 16,
    parameter int PG_TIMEOUT = 16'd1000
) (
    input  logic                       clk_in,
    input  logic                       iRst_n,
    input  logic                       iPwr_req,
    input  logic [NUM_RAILS-1:0]       iRail_pg,
    input  logic [NUM_RAILS*DLY_W-1:0] iStep_dly,
    output logic [NUM_RAILS-1:0]       oRail_en,
    output logic                       oPerst_n,
    output logic                       oSeq_done,
    output logic                       oFault,
    output logic [2:0]                 oState
);
    localparam int              KW      = $clog2(NUM_RAILS);
    localparam logic [KW-1:0]   K_LAST  = KW'(NUM_RAILS - 1);
    localparam logic [DLY_W-1:0] TO_LAST = DLY_W'(PG_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PU_WAIT = 3'd1,
        PU_DLY  = 3'd2,
        ON      = 3'd3,
        PD      = 3'd4,
        FAULT   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d, k_inc;
    logic [DLY_W-1:0]     cnt_q, cnt_d, step_dly;
    logic [NUM_RAILS-1:0] en_q, en_d;
    logic                 perst_q, perst_d, done_q, done_d, fault_q, fault_d;
    logic                 below_bad, upto_bad, enter_fault;

    function automatic logic [DLY_W-1:0] sat_inc(input logic [DLY_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign step_dly = iStep_dly[k_q*DLY_W +: DLY_W];
    assign k_inc    = k_q + 1'b1;

    // Lower-rail PG health: strictly below k while waiting, up to k once k is good.
    always_comb begin
        below_bad = 1'b0;
        upto_bad  = 1'b0;
        for (int j = 0; j < NUM_RAILS; j++) begin
            if ((KW'(j) <  k_q) && !iRail_pg[j]) below_bad = 1'b1;
            if ((KW'(j) <= k_q) && !iRail_pg[j]) upto_bad  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        en_d        = en_q;
        perst_d     = perst_q;
        done_d      = done_q;
        fault_d     = fault_q;
        enter_fault = 1'b0;
        case (state_q)
            IDLE: begin
                en_d = '0;
                if (iPwr_req) begin
                    state_d = PU_WAIT;
                    k_d     = '0;
                    cnt_d   = '0;
                    en_d    = NUM_RAILS'(1);
                end
            end
            PU_WAIT: begin
                if (below_bad) begin
                    enter_fault = 1'b1;
                end else if (!iPwr_req) begin
                    state_d = PD;
                    cnt_d   = '0;
                    perst_d = 1'b0;
                end else if (iRail_pg[k_q]) begin
                    state_d = PU_DLY;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    enter_fault = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PU_DLY: begin
                if (upto_bad) begin
                    enter_fault = 1'b1;
                end else if (!iPwr_req) begin
                    state_d = PD;
                    cnt_d   = '0;
                    perst_d = 1'b0;
                end else if (cnt_q >= step_dly) begin
                    if (k_q == K_LAST) begin
                        state_d = ON;
                        perst_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = PU_WAIT;
                        k_d         = k_inc;
                        en_d[k_inc] = 1'b1;
                        cnt_d       = '0;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ON: begin
                if (!(&iRail_pg)) begin
                    enter_fault = 1'b1;
                end else if (!iPwr_req) begin
                    state_d = PD;
                    k_d     = K_LAST;
                    cnt_d   = '0;
                    perst_d = 1'b0;
                    done_d  = 1'b0;
                end
            end
            PD: begin
                if (cnt_q >= step_dly) begin
                    en_d[k_q] = 1'b0;
                    cnt_d     = '0;
                    if (k_q == '0) state_d = IDLE;
                    else           k_d     = k_q - 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            FAULT: begin
                if (!iPwr_req) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Fault wins over every other transition chosen above.
        if (enter_fault) begin
            state_d = FAULT;
            en_d    = '0;
            perst_d = 1'b0;
            done_d  = 1'b0;
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            perst_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            perst_q <= perst_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign oRail_en  = en_q;
    assign oPerst_n  = perst_q;
    assign oSeq_done = done_q;
    assign oFault    = fault_q;
    assign oState    = state_q;

endmodule
